// File: rtl/seg7_scanner.sv
// Multiplexed 8-digit hex display back-end for the CPU: debounced source select,
// tear-free per-scan snapshot, and a sticky halt decimal point on the rightmost digit.
module seg7_scanner #(
    parameter int DIV_CYCLES      = 100000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] display,
    input  logic [31:0] cycles,
    input  logic        halt,
    input  logic        btn_src,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        src_sel
);

    localparam int DIV_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Segment pattern {g,f,e,d,c,b,a}, active-low, for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_digit_idx;
    logic [31:0]      r_snapshot;
    logic             r_src_sel;
    logic             r_halt_seen;
    logic             r_btn_meta;
    logic             r_btn_sync;
    logic             r_btn_state;
    logic [DB_W-1:0]  r_db_cnt;
    logic [7:0]       r_an_n_p1;
    logic [7:0]       r_seg_n_p1;

    logic             w_tick;
    logic             w_scan_wrap;
    logic             w_btn_accept;
    logic             w_btn_rise;
    logic [3:0]       w_nibble;

    assign w_tick       = (r_div_cnt == DIV_LAST);
    assign w_scan_wrap  = w_tick && (r_digit_idx == 3'd7);
    assign w_btn_accept = (r_btn_sync != r_btn_state) && (r_db_cnt == DB_LAST);
    assign w_btn_rise   = w_btn_accept && r_btn_sync;
    assign w_nibble     = r_snapshot[{r_digit_idx, 2'b00} +: 4];

    // Stage p0: digit timing and per-scan snapshot
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_div_cnt   <= '0;
            r_digit_idx <= 3'd0;
            r_snapshot  <= 32'd0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick)
                r_digit_idx <= r_digit_idx + 3'd1;
            // r_src_sel is the pre-toggle value here, so a same-edge toggle waits a scan.
            if (w_scan_wrap)
                r_snapshot <= r_src_sel ? cycles : display;
        end
    end

    // Button synchronizer, debouncer and source toggle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_btn_state <= 1'b0;
            r_db_cnt    <= '0;
            r_src_sel   <= 1'b0;
        end else begin
            r_btn_meta <= btn_src;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_btn_state) begin
                r_db_cnt <= '0;
            end else if (w_btn_accept) begin
                r_btn_state <= r_btn_sync;
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
            if (w_btn_rise)
                r_src_sel <= ~r_src_sel;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_halt_seen <= 1'b0;
        else
            r_halt_seen <= r_halt_seen | halt;
    end

    // Stage p1: registered anode and segment drive
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_an_n_p1  <= 8'hFF;
            r_seg_n_p1 <= 8'hFF;
        end else begin
            r_an_n_p1  <= ~(8'b1 << r_digit_idx);
            r_seg_n_p1 <= {~(r_halt_seen && (r_digit_idx == 3'd0)), hex_to_seg(w_nibble)};
        end
    end

    assign an_n    = r_an_n_p1;
    assign seg_n   = r_seg_n_p1;
    assign src_sel = r_src_sel;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboarded bench for seg7_scanner: every clock after reset release pops one
// expected {an_n, seg_n} pair; source toggle, halt and collision cases are hand-sequenced.
module tb_seg7_scanner;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] display;
    logic [31:0] cycles;
    logic        halt;
    logic        btn_src;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;
    logic        src_sel;

    always #5 clk = ~clk;

    seg7_scanner #(.DIV_CYCLES(DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .clr(clr), .display(display), .cycles(cycles), .halt(halt),
        .btn_src(btn_src), .seg_n(seg_n), .an_n(an_n), .src_sel(src_sel)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    typedef struct {
        logic [31:0]     disp;
        logic [7:0][7:0] seg;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [7:0] hexseg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [7:0][7:0] segs_of(input logic [31:0] v);
        logic [7:0][7:0] r;
        for (int d = 0; d < 8; d++)
            r[d] = hexseg(v[4*d +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One full scan: digits 0..7, each held DIV clocks; dp lit on digit-0 slots from dp_start on.
    task automatic push_scan(input logic [7:0][7:0] segs, input int dp_start);
        exp_t e;
        for (int i = 0; i < 8*DIV; i++) begin
            int d;
            d = i / DIV;
            e.an  = ~(8'b1 << d);
            e.seg = segs[d];
            if (d == 0 && i >= dp_start)
                e.seg[7] = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got no expected entry, required one per clock");
        end else begin
            e = sb.pop_front();
            check("an_n", {24'd0, an_n}, {24'd0, e.an});
            check("seg_n", {24'd0, seg_n}, {24'd0, e.seg});
        end
    endtask

    initial begin
        tbl[0].disp = 32'h89ABCDEF;
        tbl[0].seg  = {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        tbl[1].disp = 32'h01234567;
        tbl[1].seg  = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        tbl[2].disp = 32'hFEDCBA98;
        tbl[2].seg  = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        tbl[3].disp = 32'h00000001;
        tbl[3].seg  = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9};

        clr = 1'b1; halt = 1'b0; btn_src = 1'b0; display = 32'd0; cycles = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an_n", {24'd0, an_n}, 32'hFF);
        check("reset_seg_n", {24'd0, seg_n}, 32'hFF);
        check("reset_src_sel", {31'd0, src_sel}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Each table value is applied mid-scan and must appear only on the following scan.
        for (int i = 0; i < 4; i++) begin
            push_scan((i == 0) ? segs_of(32'd0) : tbl[i-1].seg, 32);
            repeat (13) cyc();
            display = tbl[i].disp;
            repeat (8*DIV - 13) cyc();
        end

        // Glitch, then a held press; the toggle lands 5 clocks after the press is driven.
        push_scan(tbl[3].seg, 32);
        cycles = 32'h00000005;
        for (int c = 1; c <= 8*DIV; c++) begin
            cyc();
            case (c)
                1:  btn_src = 1'b1;
                3:  btn_src = 1'b0;
                8:  check("glitch_no_toggle", {31'd0, src_sel}, 32'd0);
                10: btn_src = 1'b1;
                14: check("toggle_not_early", {31'd0, src_sel}, 32'd0);
                15: check("toggle_on_time", {31'd0, src_sel}, 32'd1);
                20: btn_src = 1'b0;
                32: check("release_no_toggle", {31'd0, src_sel}, 32'd1);
                default: ;
            endcase
        end

        // Halt pulse inside digit 0: dp from the third slot, then sticky.
        push_scan(segs_of(32'h00000005), 2);
        for (int c = 1; c <= 8*DIV; c++) begin
            cyc();
            if (c == 1) halt = 1'b1;
            if (c == 2) halt = 1'b0;
            if (c == 10) cycles = 32'hFEDCBA98;
        end
        push_scan(tbl[2].seg, 0);
        repeat (8*DIV) cyc();

        @(negedge clk);
        clr = 1'b1;
        #1;
        check("midscan_clr_an_n", {24'd0, an_n}, 32'hFF);
        check("midscan_clr_seg_n", {24'd0, seg_n}, 32'hFF);
        check("midscan_clr_src_sel", {31'd0, src_sel}, 32'd0);
        display = 32'h01234567;
        cycles  = 32'hFEDCBA98;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Accepted press lands on the 7->0 wrap edge: that snapshot still uses display.
        push_scan(segs_of(32'd0), 32);
        for (int c = 1; c <= 8*DIV; c++) begin
            cyc();
            if (c == 27) btn_src = 1'b1;
            if (c == 31) check("collide_before", {31'd0, src_sel}, 32'd0);
            if (c == 32) check("collide_toggle", {31'd0, src_sel}, 32'd1);
        end
        push_scan(tbl[1].seg, 32);
        repeat (8*DIV) cyc();
        check("held_single_toggle", {31'd0, src_sel}, 32'd1);
        push_scan(tbl[2].seg, 32);
        repeat (8*DIV) cyc();
        btn_src = 1'b0;

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
